riscboy_ppu_palette_mapper_v2: RTL and testbench
================================================

RISCBOY_PPU_PALETTE_MAPPER_V2 -- requirements
Module: riscboy_ppu_palette_mapper_v2

Interface
- REQ-001 SHALL have parameter W_PIXDATA, default 15: width of colour pixel data.
- REQ-002 SHALL have parameter W_PALETTE_IDX, default 8, legal range 1..10: palette RAM address width, depth 2^W_PALETTE_IDX.
- REQ-003 SHALL have ports (clock and reset first; one clock; reset asynchronous, active-low):
  clk  in  1  sole clock, all state on rising edge
  rst_n  in  1  asynchronous active-low reset
  in_vld  in  1  input pixel valid
  in_rdy  out  1  input pixel accepted when in_vld && in_rdy
  in_data  in  W_PIXDATA  direct colour, or palette index in low bits
  in_paletted  in  1  1: look up in palette; 0: pass in_data through
  in_bpp  in  2  index depth: 0=8bpp, 1=4bpp, 2=2bpp, 3=1bpp
  in_pbase  in  W_PALETTE_IDX  palette base; supplies address bits above the index
  in_transp_en  in  1  index 0 is transparent for this pixel
  pram_waddr  in  W_PALETTE_IDX  palette write address
  pram_wdata  in  W_PIXDATA  palette write data
  pram_wen  in  1  palette write strobe
  out_vld  out  1  output pixel valid
  out_rdy  in  1  downstream ready
  out_data  out  W_PIXDATA  resolved colour
  out_transp  out  1  pixel is transparent

Function
- REQ-004 SHALL hold a 2^W_PALETTE_IDX x W_PIXDATA palette RAM internally, with synchronous read and one write port.
- REQ-005 Index mask SHALL be M = 8/4/2/1 low ones for in_bpp 0/1/2/3, truncated to W_PALETTE_IDX bits.
- REQ-006 Read address SHALL be (in_pbase & ~M) | (in_data & M).
- REQ-007 The PRAM read SHALL be issued only in the accept cycle (in_vld && in_rdy && in_paletted), never from a held input.
- REQ-008 Pipeline SHALL be two registered stages: A (read/sidestep) and B (output register); minimum latency is 2 cycles from accept to out_vld.
- REQ-009 B advances when !out_vld || out_rdy. A advances into B when a_vld and B advances.
- REQ-010 in_rdy SHALL be !a_vld || A-advance (combinational); sustained throughput SHALL be 1 pixel/cycle with out_rdy held high.
- REQ-011 If A stalls in the cycle after its PRAM read, the read data SHALL be captured into a hold register. A's paletted data SHALL come from the hold register thereafter, so later reads and writes cannot corrupt it.
- REQ-012 Non-paletted pixels SHALL carry in_data through A and B unchanged, with out_transp=0.
- REQ-013 Paletted pixels SHALL give out_data = PRAM[addr] as of the accept cycle. out_transp = in_transp_en && (in_data & M)==0. out_data is still the PRAM value when transparent.
- REQ-014 A write and a read to the same address in the same cycle SHALL return the old (pre-write) data to the read.
- REQ-015 A write issued in any cycle after a pixel's accept cycle SHALL NOT affect that pixel's out_data.
- REQ-016 While out_vld && !out_rdy, out_data and out_transp SHALL be stable.
- REQ-017 Order SHALL be preserved; no pixel is dropped or duplicated.
- REQ-018 PRAM writes SHALL be accepted every cycle regardless of pipeline state.

Reset
- REQ-019 On rst_n low, a_vld, out_vld, out_transp and the hold-valid flag SHALL clear to 0 and out_data SHALL clear to 0, asynchronously.
- REQ-020 PRAM contents SHALL NOT be reset.
- REQ-021 After reset, in_rdy=1.
- REQ-022 Reset asserted mid-stream SHALL discard all in-flight pixels.

Verification
- REQ-023 Bench SHALL cover streaming: PRAM[0x25]=0x1234; send paletted 8bpp data 0x25, then direct 0x7FFF, with out_rdy=1 -> out 0x1234 at cycle +2, then 0x7FFF at +3; in_rdy stays 1.
- REQ-024 Bench SHALL cover 4bpp with base: in_pbase=0xA7, in_data=0x3, in_bpp=1 -> address 0xA3; transp_en=1 with in_data=0x10 -> out_transp=1, out_data=PRAM[0xA0].
- REQ-025 Bench SHALL cover a stall with rewrite: out_rdy=0 for 5 cycles with 2 paletted pixels in flight, rewrite both addresses during the stall -> the old colours emerge in order; in_rdy=0 once A and B are full.
- REQ-026 Bench SHALL cover a same-cycle write/read to address 0x10 (old 0x0001, new 0x0002) -> out_data=0x0001; the next read of 0x10 returns 0x0002.
- REQ-027 Bench SHALL cover reset mid-stream: rst_n pulsed low with out_vld=1 -> out_vld=0 immediately, no stale pixel after release, and PRAM contents retained.
- REQ-028 Bench SHALL cover random out_rdy/in_vld against a reference model for 10k pixels with W_PALETTE_IDX=6 -> exact match, and output stable while stalled.

Source files
------------

// File: rtl/riscboy_ppu_palette_mapper_v2.sv
// Two-stage pixel palette mapper: stage A issues the palette RAM read (or carries a direct
// colour), stage B is the output register. A hold register protects read data across stalls.
module riscboy_ppu_palette_mapper_v2 #(
  parameter int unsigned W_PIXDATA     = 15,
  parameter int unsigned W_PALETTE_IDX = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [W_PIXDATA-1:0]     in_data,
  input  logic                     in_paletted,
  input  logic [1:0]               in_bpp,
  input  logic [W_PALETTE_IDX-1:0] in_pbase,
  input  logic                     in_transp_en,
  input  logic [W_PALETTE_IDX-1:0] pram_waddr,
  input  logic [W_PIXDATA-1:0]     pram_wdata,
  input  logic                     pram_wen,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic [W_PIXDATA-1:0]     out_data,
  output logic                     out_transp
);

  localparam int unsigned Depth = 1 << W_PALETTE_IDX;

  logic [W_PIXDATA-1:0]     pram_q [Depth];
  logic [W_PIXDATA-1:0]     rdata_q;

  logic                     a_vld_q, a_vld_d;
  logic                     a_fresh_q, a_fresh_d;
  logic                     a_pal_q, a_pal_d;
  logic                     a_transp_q, a_transp_d;
  logic [W_PIXDATA-1:0]     a_data_q, a_data_d;
  logic                     hold_vld_q, hold_vld_d;
  logic [W_PIXDATA-1:0]     hold_q, hold_d;
  logic                     out_vld_q, out_vld_d;
  logic                     out_transp_q, out_transp_d;
  logic [W_PIXDATA-1:0]     out_data_q, out_data_d;

  logic [9:0]               mask_full;
  logic [W_PALETTE_IDX-1:0] mask, in_idx, raddr;
  logic                     b_adv, a_adv, accept, rd_en;
  logic [W_PIXDATA-1:0]     a_pix;

  always_comb begin
    unique case (in_bpp)
      2'd0:    mask_full = 10'h0ff;
      2'd1:    mask_full = 10'h00f;
      2'd2:    mask_full = 10'h003;
      default: mask_full = 10'h001;
    endcase
  end

  assign mask   = mask_full[W_PALETTE_IDX-1:0];
  assign in_idx = in_data[W_PALETTE_IDX-1:0];
  assign raddr  = (in_pbase & ~mask) | (in_idx & mask);

  assign b_adv  = !out_vld_q || out_rdy;
  assign a_adv  = a_vld_q && b_adv;
  assign in_rdy = !a_vld_q || a_adv;
  assign accept = in_vld && in_rdy;
  assign rd_en  = accept && in_paletted;

  // Writes land via NBA, so a same-cycle read of the same address sees the old word.
  always_ff @(posedge clk) begin
    if (pram_wen) pram_q[pram_waddr] <= pram_wdata;
    if (rd_en) rdata_q <= pram_q[raddr];
  end

  assign a_pix = hold_vld_q ? hold_q : rdata_q;

  always_comb begin
    a_vld_d      = in_rdy ? in_vld : a_vld_q;
    a_fresh_d    = rd_en;
    a_pal_d      = a_pal_q;
    a_transp_d   = a_transp_q;
    a_data_d     = a_data_q;
    hold_vld_d   = hold_vld_q;
    hold_d       = hold_q;
    out_vld_d    = b_adv ? a_vld_q : out_vld_q;
    out_data_d   = out_data_q;
    out_transp_d = out_transp_q;

    if (accept) begin
      a_pal_d    = in_paletted;
      a_data_d   = in_data;
      a_transp_d = in_paletted && in_transp_en && ((in_idx & mask) == '0);
    end
    // Capture read data the first time A fails to drain it.
    if (a_fresh_q && !a_adv) begin
      hold_vld_d = 1'b1;
      hold_d     = rdata_q;
    end
    if (a_adv) begin
      hold_vld_d   = 1'b0;
      out_data_d   = a_pal_q ? a_pix : a_data_q;
      out_transp_d = a_transp_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld_q      <= 1'b0;
      a_fresh_q    <= 1'b0;
      hold_vld_q   <= 1'b0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
      out_transp_q <= 1'b0;
    end else begin
      a_vld_q      <= a_vld_d;
      a_fresh_q    <= a_fresh_d;
      hold_vld_q   <= hold_vld_d;
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      out_transp_q <= out_transp_d;
    end
  end

  always_ff @(posedge clk) begin
    a_pal_q    <= a_pal_d;
    a_transp_q <= a_transp_d;
    a_data_q   <= a_data_d;
    hold_q     <= hold_d;
  end

  assign out_vld    = out_vld_q;
  assign out_data   = out_data_q;
  assign out_transp = out_transp_q;

endmodule

// File: tb/tb_riscboy_ppu_palette_mapper_v2.sv
// Directed checks on the default-size mapper plus a randomised scoreboard run on a
// 64-entry palette instance.
module tb_riscboy_ppu_palette_mapper_v2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Default instance (W_PALETTE_IDX = 8)
  logic        in_vld = 0, in_rdy, in_paletted = 0, in_transp_en = 0, pram_wen = 0;
  logic [14:0] in_data = 0, pram_wdata = 0, out_data;
  logic [1:0]  in_bpp = 0;
  logic [7:0]  in_pbase = 0, pram_waddr = 0;
  logic        out_vld, out_rdy = 1, out_transp;

  riscboy_ppu_palette_mapper_v2 dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
    .in_paletted(in_paletted), .in_bpp(in_bpp), .in_pbase(in_pbase),
    .in_transp_en(in_transp_en), .pram_waddr(pram_waddr), .pram_wdata(pram_wdata),
    .pram_wen(pram_wen), .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
    .out_transp(out_transp)
  );

  // Small instance (W_PALETTE_IDX = 6)
  logic        r_in_vld = 0, r_in_rdy, r_in_paletted = 0, r_in_transp_en = 0, r_wen = 0;
  logic [14:0] r_in_data = 0, r_wdata = 0, r_out_data;
  logic [1:0]  r_in_bpp = 0;
  logic [5:0]  r_in_pbase = 0, r_waddr = 0;
  logic        r_out_vld, r_out_rdy = 1, r_out_transp;

  riscboy_ppu_palette_mapper_v2 #(.W_PIXDATA(15), .W_PALETTE_IDX(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_vld(r_in_vld), .in_rdy(r_in_rdy), .in_data(r_in_data),
    .in_paletted(r_in_paletted), .in_bpp(r_in_bpp), .in_pbase(r_in_pbase),
    .in_transp_en(r_in_transp_en), .pram_waddr(r_waddr), .pram_wdata(r_wdata),
    .pram_wen(r_wen), .out_vld(r_out_vld), .out_rdy(r_out_rdy), .out_data(r_out_data),
    .out_transp(r_out_transp)
  );

  task automatic pwrite(input logic [7:0] a, input logic [14:0] d);
    @(negedge clk);
    pram_wen = 1; pram_waddr = a; pram_wdata = d;
    @(negedge clk);
    pram_wen = 0;
  endtask

  task automatic drive(input logic v, input logic pal, input logic [14:0] d,
                       input logic [1:0] bpp, input logic [7:0] pb, input logic te);
    in_vld = v; in_paletted = pal; in_data = d; in_bpp = bpp; in_pbase = pb;
    in_transp_en = te;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({in_rdy, out_vld, out_transp, out_data} !== {1'b1, 1'b0, 1'b0, 15'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy/vld/tr/data %b%b%b %h want 100 0000",
               in_rdy, out_vld, out_transp, out_data);
    end
    rst_n = 1;
    @(negedge clk); #1;
    n_tests++;
    if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin
      n_fail++; $display("FAIL post_reset_rdy: got rdy %b vld %b want 1 0", in_rdy, out_vld);
    end
  endtask

  task automatic test_streaming;
    pwrite(8'h25, 15'h1234);
    out_rdy = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) drive(1, 1, 15'h0025, 0, 8'h00, 0);
      else if (k == 1) drive(1, 0, 15'h7fff, 0, 8'h00, 0);
      else drive(0, 0, 15'h0, 0, 8'h00, 0);
      #1;
      n_tests++;
      if (k < 2 && (in_rdy !== 1'b1 || out_vld !== 1'b0)) begin
        n_fail++; $display("FAIL stream_rdy k=%0d: got rdy %b vld %b want 1 0", k, in_rdy, out_vld);
      end else if (k == 2 && {out_vld, out_transp, out_data} !== {2'b10, 15'h1234}) begin
        n_fail++; $display("FAIL stream_pal: got vld %b data %h want 1 1234", out_vld, out_data);
      end else if (k == 3 && {out_vld, out_transp, out_data} !== {2'b10, 15'h7fff}) begin
        n_fail++; $display("FAIL stream_direct: got vld %b data %h want 1 7fff", out_vld, out_data);
      end else if (k == 4 && out_vld !== 1'b0) begin
        n_fail++; $display("FAIL stream_drain: got vld %b want 0", out_vld);
      end
    end
  endtask

  task automatic test_bpp_base;
    logic [7:0]  pb [5]  = '{8'ha7, 8'ha7, 8'h55, 8'hf0, 8'h00};
    logic [14:0] dd [5]  = '{15'h0003, 15'h0010, 15'h0003, 15'h0006, 15'h0100};
    logic [1:0]  bp [5]  = '{2'd1, 2'd1, 2'd3, 2'd2, 2'd0};
    logic        te [5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [14:0] ed [5]  = '{15'h0a3a, 15'h00a0, 15'h0555, 15'h0f2f, 15'h0101};
    logic        et [5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    pwrite(8'ha3, 15'h0a3a); pwrite(8'ha0, 15'h00a0); pwrite(8'h03, 15'h7003);
    pwrite(8'h55, 15'h0555); pwrite(8'hf2, 15'h0f2f); pwrite(8'h00, 15'h0101);
    out_rdy = 1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 5) drive(1, 1, dd[k], bp[k], pb[k], te[k]);
      else drive(0, 0, 15'h0, 0, 8'h00, 0);
      #1;
      if (k >= 2) begin
        n_tests++;
        if ({out_vld, out_transp, out_data} !== {1'b1, et[k-2], ed[k-2]}) begin
          n_fail++;
          $display("FAIL bpp_px%0d: got vld %b tr %b data %h want 1 %b %h",
                   k - 2, out_vld, out_transp, out_data, et[k-2], ed[k-2]);
        end
      end
    end
  endtask

  task automatic test_stall_rewrite;
    pwrite(8'h40, 15'h0440); pwrite(8'h41, 15'h0441);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      pram_wen = 0;
      case (k)
        0: begin out_rdy = 0; drive(1, 1, 15'h0040, 0, 8'h00, 0); end
        1: drive(1, 1, 15'h0041, 0, 8'h00, 0);
        2: begin
          drive(1, 0, 15'h1111, 0, 8'h00, 0);
          pram_wen = 1; pram_waddr = 8'h40; pram_wdata = 15'h7777;
        end
        3: begin pram_wen = 1; pram_waddr = 8'h41; pram_wdata = 15'h7778; end
        7: out_rdy = 1;
        8: drive(0, 0, 15'h0, 0, 8'h00, 0);
        default: ;
      endcase
      #1;
      if (k == 1) begin
        n_tests++;
        if (in_rdy !== 1'b1) begin
          n_fail++; $display("FAIL stall_rdy_fill: got %b want 1", in_rdy);
        end
      end else if (k >= 2 && k <= 7) begin
        n_tests++;
        if ({in_rdy, out_vld, out_data} !== {k == 7, 1'b1, 15'h0440}) begin
          n_fail++;
          $display("FAIL stall_hold k=%0d: got rdy %b vld %b data %h want %b 1 0440",
                   k, in_rdy, out_vld, out_data, k == 7);
        end
      end else if (k == 8 || k == 9) begin
        n_tests++;
        if ({out_vld, out_data} !== {1'b1, (k == 8) ? 15'h0441 : 15'h1111}) begin
          n_fail++;
          $display("FAIL stall_order k=%0d: got vld %b data %h", k, out_vld, out_data);
        end
      end else if (k == 10) begin
        n_tests++;
        if (out_vld !== 1'b0) begin
          n_fail++; $display("FAIL stall_nodup: got vld %b want 0", out_vld);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k < 2) drive(1, 1, (k == 0) ? 15'h0040 : 15'h0041, 0, 8'h00, 0);
      else drive(0, 0, 15'h0, 0, 8'h00, 0);
      #1;
      if (k >= 2) begin
        n_tests++;
        if ({out_vld, out_data} !== {1'b1, (k == 2) ? 15'h7777 : 15'h7778}) begin
          n_fail++; $display("FAIL stall_newval k=%0d: got vld %b data %h", k, out_vld, out_data);
        end
      end
    end
  endtask

  task automatic test_same_cycle_rw;
    pwrite(8'h10, 15'h0001);
    out_rdy = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pram_wen = (k == 0); pram_waddr = 8'h10; pram_wdata = 15'h0002;
      if (k < 2) drive(1, 1, 15'h0010, 0, 8'h00, 0);
      else drive(0, 0, 15'h0, 0, 8'h00, 0);
      #1;
      if (k >= 2) begin
        n_tests++;
        if ({out_vld, out_data} !== {1'b1, (k == 2) ? 15'h0001 : 15'h0002}) begin
          n_fail++; $display("FAIL rw_same k=%0d: got vld %b data %h", k, out_vld, out_data);
        end
      end
    end
    pram_wen = 0;
  endtask

  task automatic test_reset_midstream;
    pwrite(8'h30, 15'h0333);
    out_rdy = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k < 2) drive(1, 1, 15'h0030, 0, 8'h00, 0);
      else drive(0, 0, 15'h0, 0, 8'h00, 0);
    end
    #1;
    n_tests++;
    if (out_vld !== 1'b1 || in_rdy !== 1'b0) begin
      n_fail++; $display("FAIL rst_pre: got vld %b rdy %b want 1 0", out_vld, in_rdy);
    end
    #1 rst_n = 0;
    #1;
    n_tests++;
    if ({out_vld, out_transp, out_data, in_rdy} !== {2'b00, 15'h0, 1'b1}) begin
      n_fail++; $display("FAIL rst_async: got vld %b data %h rdy %b want 0 0000 1",
                         out_vld, out_data, in_rdy);
    end
    @(negedge clk);
    rst_n = 1; out_rdy = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      n_tests++;
      if (out_vld !== 1'b0) begin
        n_fail++; $display("FAIL rst_stale k=%0d: got vld %b want 0", k, out_vld);
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) drive(1, 1, 15'h0030, 0, 8'h00, 0);
      else drive(0, 0, 15'h0, 0, 8'h00, 0);
      #1;
      if (k == 2) begin
        n_tests++;
        if ({out_vld, out_data} !== {1'b1, 15'h0333}) begin
          n_fail++; $display("FAIL rst_pram_kept: got vld %b data %h want 1 0333",
                             out_vld, out_data);
        end
      end
    end
  endtask

  task automatic test_random_stream;
    logic [14:0] shadow [64];
    logic [14:0] q_data [$];
    logic        q_tr [$];
    logic [14:0] prev_d, ed;
    logic        prev_t, prev_stall, et;
    logic [5:0]  m, addr;
    int          nbits, pushed, cycles, pix_fail;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      r_wen = 1; r_waddr = 6'(i); r_wdata = 15'($urandom);
      shadow[i] = r_wdata;
    end
    pushed = 0; cycles = 0; pix_fail = 0; prev_stall = 0; prev_d = 0; prev_t = 0;
    while ((pushed < 10000 || q_data.size() > 0) && cycles < 60000) begin
      @(negedge clk);
      r_in_vld       = (pushed < 10000) && ($urandom_range(0, 3) != 0);
      r_in_paletted  = 1'($urandom);
      r_in_data      = 15'($urandom);
      r_in_bpp       = 2'($urandom);
      r_in_pbase     = 6'($urandom);
      r_in_transp_en = 1'($urandom);
      r_out_rdy      = ($urandom_range(0, 2) != 0);
      r_wen          = 1'($urandom);
      r_waddr        = 6'($urandom);
      r_wdata        = 15'($urandom);
      #1;
      if (prev_stall) begin
        n_tests++;
        if ({r_out_vld, r_out_transp, r_out_data} !== {1'b1, prev_t, prev_d}) begin
          n_fail++;
          $display("FAIL rand_stable cyc=%0d: got vld %b tr %b data %h want 1 %b %h",
                   cycles, r_out_vld, r_out_transp, r_out_data, prev_t, prev_d);
        end
      end
      if (r_out_vld && r_out_rdy) begin
        n_tests++;
        if (q_data.size() == 0) begin
          n_fail++; $display("FAIL rand_extra cyc=%0d: got data %h want none", cycles, r_out_data);
        end else begin
          ed = q_data.pop_front(); et = q_tr.pop_front();
          if ({r_out_transp, r_out_data} !== {et, ed}) begin
            n_fail++;
            if (pix_fail < 10)
              $display("FAIL rand_pixel cyc=%0d: got tr %b data %h want %b %h",
                       cycles, r_out_transp, r_out_data, et, ed);
            pix_fail++;
          end
        end
      end
      if (r_in_vld && r_in_rdy) begin
        nbits = (r_in_bpp == 0) ? 8 : (r_in_bpp == 1) ? 4 : (r_in_bpp == 2) ? 2 : 1;
        m = 6'((1 << nbits) - 1);
        addr = (r_in_pbase & ~m) | (r_in_data[5:0] & m);
        q_data.push_back(r_in_paletted ? shadow[addr] : r_in_data);
        q_tr.push_back(r_in_paletted && r_in_transp_en && ((r_in_data[5:0] & m) == 0));
        pushed++;
      end
      if (r_wen) shadow[r_waddr] = r_wdata;
      prev_stall = r_out_vld && !r_out_rdy;
      prev_d = r_out_data; prev_t = r_out_transp;
      cycles++;
    end
    @(negedge clk);
    r_in_vld = 0; r_wen = 0; r_out_rdy = 1;
    n_tests++;
    if (pushed != 10000 || q_data.size() != 0) begin
      n_fail++; $display("FAIL rand_complete: got pushed %0d left %0d want 10000 0",
                         pushed, q_data.size());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_streaming();
    test_bpp_base();
    test_stall_rewrite();
    test_same_cycle_rw();
    test_reset_midstream();
    test_random_stream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
